main_mem_ctrl: RTL and testbench

- Parametrised, latency-modelled line-granular main memory that backs the L1 caches.
- Serves full cache-line reads and full-line writebacks with per-byte strobes.
- A single FSM with a ready/done handshake and a configurable access latency replaces the fixed one-cycle model.
- Sits below the cache controllers' read/write channels.

---
 rtl/main_mem_pkg.sv | 23 ++
 rtl/main_mem_ctrl_if.sv | 34 +++
 rtl/main_mem_ctrl_line_ram.sv | 32 +++
 rtl/main_mem_ctrl.sv | 114 +++++++++++
 tb/tb_main_mem_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/main_mem_pkg.sv
// Shared types and derived-geometry helpers for the line-granular main memory.
package main_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT
  } mem_state_e;

  function automatic int unsigned line_bytes(input int unsigned line_width);
    return line_width / 8;
  endfunction

  function automatic int unsigned offset_bits(input int unsigned line_width);
    return $clog2(line_width / 8);
  endfunction

  // One extra bit so the largest latency-1 always fits.
  function automatic int unsigned cnt_width(input int unsigned rd_lat, input int unsigned wr_lat);
    return $clog2((rd_lat > wr_lat) ? rd_lat : wr_lat) + 1;
  endfunction

endpackage

// File: rtl/main_mem_ctrl_if.sv
// Read/writeback channel between the cache controllers (master) and main memory (slave).
interface main_mem_ctrl_if
  import main_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned CACHE_LINE_WIDTH = 256
);
  localparam int unsigned LINE_BYTES = line_bytes(CACHE_LINE_WIDTH);

  logic                        o_mem_ready;
  logic                        o_mem_busy;
  logic                        i_mem_read_req;
  logic [ADDR_WIDTH-1:0]       i_mem_read_address;
  logic                        o_mem_read_done;
  logic [CACHE_LINE_WIDTH-1:0] o_cache_line;
  logic                        i_mem_write_valid;
  logic [ADDR_WIDTH-1:0]       i_mem_write_address;
  logic [CACHE_LINE_WIDTH-1:0] i_mem_write_data;
  logic [LINE_BYTES-1:0]       i_write_strobe;
  logic                        o_mem_write_done;

  modport master (
    input  o_mem_ready, o_mem_busy, o_mem_read_done, o_cache_line, o_mem_write_done,
    output i_mem_read_req, i_mem_read_address, i_mem_write_valid,
           i_mem_write_address, i_mem_write_data, i_write_strobe
  );

  modport slave (
    output o_mem_ready, o_mem_busy, o_mem_read_done, o_cache_line, o_mem_write_done,
    input  i_mem_read_req, i_mem_read_address, i_mem_write_valid,
           i_mem_write_address, i_mem_write_data, i_write_strobe
  );

endinterface

// File: rtl/main_mem_ctrl_line_ram.sv
// Single-port line store: registered read with synchronous output clear, byte-enable write.
module line_ram #(
  parameter int unsigned DEPTH = 10,
  parameter int unsigned WIDTH = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DEPTH-1:0]   addr,
  input  logic               re,
  input  logic               we,
  input  logic [WIDTH/8-1:0] be,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned k = 0; k < WIDTH / 8; k++) begin
        if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  // Output register holds between reads; the contents themselves survive reset.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/main_mem_ctrl.sv
// Latency-modelled main memory: one FSM serialises full-line reads and strobed writebacks.
module main_mem_ctrl
  import main_mem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH        = 10,
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned CACHE_LINE_WIDTH = 256,
  parameter int unsigned RD_LATENCY       = 4,
  parameter int unsigned WR_LATENCY       = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  main_mem_ctrl_if.slave bus
);

  localparam int unsigned LINE_BYTES  = line_bytes(CACHE_LINE_WIDTH);
  localparam int unsigned OFFSET_BITS = offset_bits(CACHE_LINE_WIDTH);
  localparam int unsigned CNT_W       = cnt_width(RD_LATENCY, WR_LATENCY);

  mem_state_e                  state;
  logic [CNT_W-1:0]            cnt;
  logic [MEM_DEPTH-1:0]        idx;
  logic [CACHE_LINE_WIDTH-1:0] wdata;
  logic [LINE_BYTES-1:0]       strb;
  logic                        ready;
  logic                        rd_done;
  logic                        wr_done;
  logic                        ram_re;
  logic                        ram_we;
  logic [CACHE_LINE_WIDTH-1:0] ram_rdata;
  logic                        unused_addr;

  // Only the line-index field of each address is meaningful.
  assign unused_addr = ^{bus.i_mem_read_address, bus.i_mem_write_address};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ready   <= 1'b1;
      rd_done <= 1'b0;
      wr_done <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      wr_done <= 1'b0;
      case (state)
        IDLE: begin
          // Write wins a tie so a dirty victim is evicted before its refill.
          if (bus.i_mem_write_valid) begin
            idx   <= bus.i_mem_write_address[OFFSET_BITS +: MEM_DEPTH];
            wdata <= bus.i_mem_write_data;
            strb  <= bus.i_write_strobe;
            cnt   <= CNT_W'(WR_LATENCY - 1);
            state <= WR_WAIT;
            ready <= 1'b0;
          end else if (bus.i_mem_read_req) begin
            idx   <= bus.i_mem_read_address[OFFSET_BITS +: MEM_DEPTH];
            cnt   <= CNT_W'(RD_LATENCY - 1);
            state <= RD_WAIT;
            ready <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rd_done <= 1'b1;
            state   <= IDLE;
            ready   <= 1'b1;
          end
        end
        WR_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            wr_done <= 1'b1;
            state   <= IDLE;
            ready   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          ready <= 1'b1;
        end
      endcase
    end
  end

  // RAM access lands on the same edge as the done pulse; reset at that edge suppresses it.
  assign ram_re = (state == RD_WAIT) && (cnt == '0) && !i_rst;
  assign ram_we = (state == WR_WAIT) && (cnt == '0) && !i_rst;

  line_ram #(
    .DEPTH(MEM_DEPTH),
    .WIDTH(CACHE_LINE_WIDTH)
  ) u_ram (
    .clk  (i_clk),
    .rst  (i_rst),
    .addr (idx),
    .re   (ram_re),
    .we   (ram_we),
    .be   (strb),
    .wdata(wdata),
    .rdata(ram_rdata)
  );

  assign bus.o_mem_ready      = ready;
  assign bus.o_mem_busy       = ~ready;
  assign bus.o_mem_read_done  = rd_done;
  assign bus.o_mem_write_done = wr_done;
  assign bus.o_cache_line     = ram_rdata;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Directed bench for main_mem_ctrl: default-latency instance plus an RD=1/WR=7 instance.
module tb_main_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  main_mem_ctrl_if #(.ADDR_WIDTH(32), .CACHE_LINE_WIDTH(256)) if0 ();
  main_mem_ctrl_if #(.ADDR_WIDTH(32), .CACHE_LINE_WIDTH(256)) if1 ();

  main_mem_ctrl #(
    .MEM_DEPTH(10), .ADDR_WIDTH(32), .CACHE_LINE_WIDTH(256),
    .RD_LATENCY(4), .WR_LATENCY(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .bus(if0)
  );

  main_mem_ctrl #(
    .MEM_DEPTH(10), .ADDR_WIDTH(32), .CACHE_LINE_WIDTH(256),
    .RD_LATENCY(1), .WR_LATENCY(7)
  ) dut_lat (
    .i_clk(clk), .i_rst(rst), .bus(if1)
  );

  localparam logic [255:0] D1 =
    256'h201f1e1d1c1b1a191817161514131211100f0e0d0c0b0a090807060504030201;
  localparam logic [255:0] ONES = {256{1'b1}};
  localparam logic [255:0] D2 = {8{32'hDEADBEEF}};
  localparam logic [255:0] D3 = {8{32'h13572468}};
  localparam logic [255:0] D4 = {8{32'h0F1E2D3C}};
  localparam logic [255:0] A5 = {32{8'hA5}};
  localparam logic [255:0] PARTIAL = {{224{1'b1}}, 32'h0};

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
    logic [31:0]  strb;
    logic [255:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input int inst, input bit wr, input bit rd, input logic [31:0] addr,
                       input logic [255:0] data, input logic [31:0] strb);
    if (inst == 0) begin
      if0.i_mem_write_valid = wr;   if0.i_mem_read_req = rd;
      if0.i_mem_write_address = addr; if0.i_mem_read_address = addr;
      if0.i_mem_write_data = data;  if0.i_write_strobe = strb;
    end else begin
      if1.i_mem_write_valid = wr;   if1.i_mem_read_req = rd;
      if1.i_mem_write_address = addr; if1.i_mem_read_address = addr;
      if1.i_mem_write_data = data;  if1.i_write_strobe = strb;
    end
  endtask

  function automatic logic done_of(input int inst, input bit wr);
    if (inst == 0) return wr ? if0.o_mem_write_done : if0.o_mem_read_done;
    return wr ? if1.o_mem_write_done : if1.o_mem_read_done;
  endfunction

  function automatic logic ready_of(input int inst);
    return (inst == 0) ? if0.o_mem_ready : if1.o_mem_ready;
  endfunction

  function automatic logic busy_of(input int inst);
    return (inst == 0) ? if0.o_mem_busy : if1.o_mem_busy;
  endfunction

  function automatic logic [255:0] line_of(input int inst);
    return (inst == 0) ? if0.o_cache_line : if1.o_cache_line;
  endfunction

  // One complete transaction: accept, count cycles to done, check the single-cycle pulse.
  task automatic xact(input string nm, input int inst, input bit wr, input logic [31:0] addr,
                      input logic [255:0] data, input logic [31:0] strb, input int exp_lat,
                      input bit chk_line, input logic [255:0] exp);
    int lat;
    logic [255:0] line;
    logic rdy;
    lat  = -1;
    line = '0;
    rdy  = 1'b0;
    drive(inst, wr, !wr, addr, data, strb);
    step();
    chk({nm, "_busy"}, 256'(busy_of(inst)), 256'(1));
    drive(inst, 1'b0, 1'b0, '0, '0, '0);
    for (int n = 1; n <= 20; n++) begin
      step();
      if (done_of(inst, wr)) begin
        lat  = n;
        line = line_of(inst);
        rdy  = ready_of(inst);
        break;
      end
    end
    chk({nm, "_lat"}, 256'(lat), 256'(exp_lat));
    chk({nm, "_rdy_at_done"}, 256'(rdy), 256'(1));
    if (chk_line) chk({nm, "_line"}, line, exp);
    step();
    chk({nm, "_pulse_end"}, 256'(done_of(inst, wr)), 256'(0));
  endtask

  initial begin
    int lat;
    int wr_seen;
    int rd_seen;

    vecs[0] = '{1'b1, 32'h0000_0040, D1,   32'hFFFF_FFFF, '0};
    vecs[1] = '{1'b0, 32'h0000_0040, '0,   '0,            D1};
    vecs[2] = '{1'b1, 32'h0000_0060, ONES, 32'hFFFF_FFFF, '0};
    vecs[3] = '{1'b1, 32'h0000_0060, '0,   32'h0000_000F, '0};
    vecs[4] = '{1'b0, 32'h0000_0060, '0,   '0,            PARTIAL};
    vecs[5] = '{1'b1, 32'h0000_8020, D2,   32'hFFFF_FFFF, '0};
    vecs[6] = '{1'b0, 32'h0000_0020, '0,   '0,            D2};
    vecs[7] = '{1'b0, 32'h0000_0027, '0,   '0,            D2};
    vecs[8] = '{1'b1, 32'h0000_0040, '0,   32'h0000_0000, '0};
    vecs[9] = '{1'b0, 32'h0000_0040, '0,   '0,            D1};

    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    chk("rst_ready0", 256'(if0.o_mem_ready), 256'(1));
    chk("rst_busy0",  256'(if0.o_mem_busy), 256'(0));
    chk("rst_rdone0", 256'(if0.o_mem_read_done), 256'(0));
    chk("rst_wdone0", 256'(if0.o_mem_write_done), 256'(0));
    chk("rst_line0",  if0.o_cache_line, '0);
    chk("rst_ready1", 256'(if1.o_mem_ready), 256'(1));
    chk("rst_line1",  if1.o_cache_line, '0);

    foreach (vecs[i]) begin
      xact($sformatf("v%0d", i), 0, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb,
           4, !vecs[i].wr, vecs[i].exp);
    end

    // Simultaneous read+write to 0x80: write first, held read accepted in the write-done cycle.
    drive(0, 1'b1, 1'b1, 32'h0000_0080, A5, 32'hFFFF_FFFF);
    step();
    if0.i_mem_write_valid = 1'b0;
    lat = -1;
    rd_seen = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (if0.o_mem_read_done) rd_seen++;
      if (if0.o_mem_write_done) begin
        lat = n;
        break;
      end
    end
    chk("sim_wr_lat", 256'(lat), 256'(4));
    chk("sim_no_early_rd", 256'(rd_seen), 256'(0));
    chk("sim_rdy_at_wdone", 256'(if0.o_mem_ready), 256'(1));
    step();
    chk("sim_rd_accepted", 256'(if0.o_mem_busy), 256'(1));
    if0.i_mem_read_req = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (if0.o_mem_read_done) begin
        lat = n;
        break;
      end
    end
    chk("sim_rd_lat", 256'(lat), 256'(4));
    chk("sim_rd_line", if0.o_cache_line, A5);
    step();
    chk("sim_line_hold", if0.o_cache_line, A5);

    // Reset two cycles into a write of zeros over D1: nothing may be committed.
    drive(0, 1'b1, 1'b0, 32'h0000_0040, '0, 32'hFFFF_FFFF);
    step();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_ready", 256'(if0.o_mem_ready), 256'(1));
    chk("mrst_wdone", 256'(if0.o_mem_write_done), 256'(0));
    chk("mrst_rdone", 256'(if0.o_mem_read_done), 256'(0));
    chk("mrst_line",  if0.o_cache_line, '0);
    wr_seen = 0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (if0.o_mem_write_done) wr_seen++;
    end
    chk("mrst_no_wdone", 256'(wr_seen), 256'(0));
    xact("mrst_rb", 0, 1'b0, 32'h0000_0040, '0, '0, 4, 1'b1, D1);

    // Latency sweep on the RD=1 / WR=7 instance.
    xact("lat_w0", 1, 1'b1, 32'h0000_0100, D3, 32'hFFFF_FFFF, 7, 1'b0, '0);
    xact("lat_w1", 1, 1'b1, 32'h0000_0120, D4, 32'hFFFF_FFFF, 7, 1'b0, '0);
    xact("lat_r0", 1, 1'b0, 32'h0000_0100, '0, '0, 1, 1'b1, D3);

    // Held read request, address switched in each done cycle: one line per two cycles.
    drive(1, 1'b0, 1'b1, 32'h0000_0120, '0, '0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("b2b%0d_busy", k), 256'(if1.o_mem_ready), 256'(0));
      chk($sformatf("b2b%0d_nodone", k), 256'(if1.o_mem_read_done), 256'(0));
      step();
      chk($sformatf("b2b%0d_done", k), 256'(if1.o_mem_read_done), 256'(1));
      chk($sformatf("b2b%0d_rdy", k), 256'(if1.o_mem_ready), 256'(1));
      chk($sformatf("b2b%0d_line", k), if1.o_cache_line, (k % 2 == 0) ? D4 : D3);
      if1.i_mem_read_address = (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0120;
    end
    if1.i_mem_read_req = 1'b0;
    step();
    chk("b2b_idle_after", 256'(if1.o_mem_read_done), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
